// File: rtl/heichips25_iout_pkg.sv
// Shared types and pin-map constants for the iout edge counter.
// Optional build macro: IOUT_GLITCH_FILTER_EN.
package heichips25_iout_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    SEND = 2'd2
  } state_e;

  localparam int VALID_BIT = 0;
  localparam int READY_BIT = 1;
  localparam int BUSY_BIT  = 2;
  localparam int OVF_BIT   = 3;

  localparam int UI_START = 0;
  localparam int UI_CONT  = 1;

  localparam logic [7:0] UIO_OE_VAL = 8'h0D;

endpackage

// File: rtl/heichips25_iout_sync.sv
// iout synchroniser, optional majority filter, registered rising-edge pulse.
// IOUT_GLITCH_FILTER_EN adds a 3-sample majority vote (latency 3 -> 4).
module heichips25_iout_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic iout,
  output logic edge_p
);

  logic [1:0] sync_q;
  logic       lvl;
  logic       prev_q;
  logic       edge_q;

`ifdef IOUT_GLITCH_FILTER_EN
  logic [1:0] hist_q;

  // two of the last three samples must agree, so 1-cycle pulses vanish
  assign lvl = (sync_q[1] & hist_q[0])
             | (sync_q[1] & hist_q[1])
             | (hist_q[0] & hist_q[1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
    end
  end
`else
  assign lvl = sync_q[1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], iout};
      prev_q <= lvl;
      edge_q <= lvl & ~prev_q;
    end
  end

  assign edge_p = edge_q;

endmodule

// File: rtl/heichips25_iout_counter.sv
// Gated rising-edge counter on iout, result streamed MSB byte first.
// Optional build macro: IOUT_GLITCH_FILTER_EN (see heichips25_iout_sync).
module heichips25_iout_counter
  import heichips25_iout_pkg::*;
#(
  parameter int CNT_W         = 24,
  parameter int GATE_MIN_LOG2 = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       iout
);

  localparam int NB    = CNT_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int GW    = GATE_MIN_LOG2 + 4;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [1:0]         g_q, g_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         last_q, last_d;

  logic               edge_p;
  logic               start;
  logic               cont;
  logic               ready;
  logic [1:0]         g_in;
  logic [GW-1:0]      win_last;
  logic               gate_end;
  logic               last_byte;
  logic [7:0]         cur_byte;
  logic               unused;

  assign unused = &{1'b0, ena, ui_in[7:6], ui_in[3:2],
                    uio_in[7:2], uio_in[0]};

  heichips25_iout_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .iout   (iout),
    .edge_p (edge_p)
  );

  assign start     = ui_in[UI_START];
  assign cont      = ui_in[UI_CONT];
  assign g_in      = ui_in[5:4];
  assign ready     = uio_in[READY_BIT];
  assign win_last  = (GW'(1) << (GATE_MIN_LOG2 + int'(g_q)))
                   - GW'(1);
  assign gate_end  = (gcnt_q == win_last);
  assign last_byte = (idx_q == IDX_W'(NB - 1));

  always_comb begin
    cur_byte = cnt_q[CNT_W-1 -: 8];
    for (int i = 0; i < NB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_byte = cnt_q[CNT_W-1-8*i -: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      g_q     <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      g_q     <= g_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    g_d     = g_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          state_d = GATE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          gcnt_d  = '0;
          g_d     = g_in;
          idx_d   = '0;
        end
      end
      (state_q == GATE): begin
        gcnt_d = gcnt_q + GW'(1);
        if (edge_p) begin
          if (&cnt_q) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (gate_end) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      (state_q == SEND): begin
        if (ready) begin
          if (last_byte) begin
            last_d = cur_byte;
            idx_d  = '0;
            // back-to-back window: no IDLE cycle in between
            if (cont) begin
              state_d = GATE;
              cnt_d   = '0;
              ovf_d   = 1'b0;
              gcnt_d  = '0;
              g_d     = g_in;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    uo_out             = (state_q == SEND) ? cur_byte : last_q;
    uio_out            = '0;
    uio_out[VALID_BIT] = (state_q == SEND);
    uio_out[BUSY_BIT]  = (state_q == GATE);
    uio_out[OVF_BIT]   = ovf_q;
    uio_oe             = UIO_OE_VAL;
  end

endmodule

// File: tb/tb_heichips25_iout_counter.sv
// Directed + randomized bench for heichips25_iout_counter (24- and 8-bit).
// Expected counts come from a list of iout rise times and the window bounds.
module tb_heichips25_iout_counter;

`ifdef IOUT_GLITCH_FILTER_EN
  localparam int LAT  = 4;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui, uii, ui8, uii8;
  logic       iout;
  logic [7:0] uo, uio, oe;
  logic [7:0] uo8, uio8, oe8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;
  int per   = 8;
  int hi    = 4;
  int ph    = 0;
  int rises[$];

  always #5 clk = ~clk;

  heichips25_iout_counter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui),
    .uo_out  (uo),
    .uio_in  (uii),
    .uio_out (uio),
    .uio_oe  (oe),
    .iout    (iout)
  );

  heichips25_iout_counter #(.CNT_W(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui8),
    .uo_out  (uo8),
    .uio_in  (uii8),
    .uio_out (uio8),
    .uio_oe  (oe8),
    .iout    (iout)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // advance one clock; iout waveform is a pure function of the cycle number
  task automatic tick();
    logic nv;
    @(posedge clk);
    #1;
    cyc++;
    nv = (mode != 0) && (((cyc + ph) % per) < hi);
    if (nv && !iout && (!FILT || hi >= 2)) rises.push_back(cyc);
    iout = nv;
  endtask

  function automatic int edges_in(input int ws, input int we);
    int n = 0;
    foreach (rises[i])
      if (rises[i] + LAT >= ws && rises[i] + LAT <= we) n++;
    return n;
  endfunction

  task automatic set_pat(input int m, input int p, input int h);
    mode = 0;
    repeat (6) tick();
    per  = p;
    hi   = h;
    ph   = $urandom_range(p - 1);
    mode = m;
  endtask

  task automatic drive(input bit sel, input bit st, input bit ct,
                       input int g, input bit rdy);
    logic [7:0] u, r;
    u      = 8'h00;
    u[0]   = st;
    u[1]   = ct;
    u[5:4] = g[1:0];
    r      = 8'h00;
    r[1]   = rdy;
    if (sel) begin
      ui8 = u; uii8 = r; ui = 8'h00; uii = 8'h00;
    end else begin
      ui = u; uii = r; ui8 = 8'h00; uii8 = 8'h00;
    end
  endtask

  function automatic logic valid_of(input bit sel);
    return sel ? uio8[0] : uio[0];
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? uio8[2] : uio[2];
  endfunction
  function automatic logic ovf_of(input bit sel);
    return sel ? uio8[3] : uio[3];
  endfunction
  function automatic logic [7:0] byte_of(input bit sel);
    return sel ? uo8 : uo;
  endfunction

  // one gate window plus its byte stream
  task automatic run_win(input bit sel, input int g, input bit do_start,
                         input bit cont_after, input int hold,
                         input string tag);
    int w, nb, nlen, ws, n, h;
    logic [31:0] c, mx;
    logic ov;
    logic [7:0] eb;
    w    = sel ? 8 : 24;
    nb   = w / 8;
    nlen = 1 << (8 + g);
    eb   = 8'h00;
    if (do_start) begin
      drive(sel, 1'b1, 1'b0, g, 1'b0);
      tick();
      drive(sel, 1'b0, 1'b0, g, 1'b0);
    end
    ws = cyc;
    for (int i = 0; i < nlen; i++) begin
      if (i == 0) chk({tag, ".ovf_clr"}, 32'(ovf_of(sel)), 32'd0);
      chk({tag, ".busy"}, 32'(busy_of(sel)), 32'd1);
      tick();
    end
    chk({tag, ".busy_end"}, 32'(busy_of(sel)), 32'd0);
    n  = edges_in(ws, ws + nlen - 1);
    mx = (w == 8) ? 32'hFF : 32'hFF_FFFF;
    c  = (n > mx) ? mx : 32'(n);
    ov = (n > mx);
    for (int b = 0; b < nb; b++) begin
      h  = (hold < 0) ? $urandom_range(3) : hold;
      eb = 8'(c >> (8 * (nb - 1 - b)));
      repeat (h) begin
        drive(sel, 1'b0, 1'b0, g, 1'b0);
        chk({tag, ".hold_valid"}, 32'(valid_of(sel)), 32'd1);
        chk({tag, ".hold_byte"}, 32'(byte_of(sel)), 32'(eb));
        tick();
      end
      drive(sel, 1'b0, (b == nb - 1) && cont_after, g, 1'b1);
      chk({tag, ".valid"}, 32'(valid_of(sel)), 32'd1);
      chk({tag, ".byte"}, 32'(byte_of(sel)), 32'(eb));
      chk({tag, ".ovf"}, 32'(ovf_of(sel)), 32'(ov));
      tick();
    end
    drive(sel, 1'b0, 1'b0, g, 1'b0);
    if (!cont_after) begin
      chk({tag, ".idle_busy"}, 32'(busy_of(sel)), 32'd0);
      chk({tag, ".idle_valid"}, 32'(valid_of(sel)), 32'd0);
      chk({tag, ".idle_byte"}, 32'(byte_of(sel)), 32'(eb));
      chk({tag, ".idle_ovf"}, 32'(ovf_of(sel)), 32'(ov));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int p, h, g, chain;
    rst_n = 1'b0;
    ena   = 1'b1;
    iout  = 1'b0;
    ui    = 8'h01;
    ui8   = 8'h01;
    uii   = 8'h02;
    uii8  = 8'h02;
    per   = 2;
    hi    = 1;
    mode  = 1;
    tick();
    tick();
    chk("rst.uo", 32'(uo), 32'h00);
    chk("rst.uio", 32'(uio), 32'h00);
    chk("rst.oe", 32'(oe), 32'h0D);
    chk("rst.uo8", 32'(uo8), 32'h00);
    chk("rst.uio8", 32'(uio8), 32'h00);
    chk("rst.oe8", 32'(oe8), 32'h0D);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst.busy", 32'(busy_of(1'b0)), 32'd0);
    chk("post_rst.valid", 32'(valid_of(1'b0)), 32'd0);
    chk("post_rst.busy8", 32'(busy_of(1'b1)), 32'd0);

    set_pat(1, 8, 4);
    run_win(1'b0, 0, 1'b1, 1'b0, 0, "p8");

    set_pat(1, 6, 3);
    run_win(1'b0, 0, 1'b1, 1'b0, 10, "bp");

    set_pat(1, 4, 2);
    run_win(1'b1, 3, 1'b1, 1'b0, -1, "sat");
    set_pat(0, 4, 2);
    run_win(1'b1, 0, 1'b1, 1'b0, -1, "sat_clr");

    set_pat(1, 10, 5);
    run_win(1'b0, 1, 1'b1, 1'b1, 0, "cont1");
    run_win(1'b0, 1, 1'b0, 1'b0, 2, "cont2");

    set_pat(1, 7, 3);
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (50) tick();
    rst_n = 1'b0;
    tick();
    chk("gate_rst.busy", 32'(busy_of(1'b0)), 32'd0);
    chk("gate_rst.valid", 32'(valid_of(1'b0)), 32'd0);
    chk("gate_rst.uo", 32'(uo), 32'h00);
    rst_n = 1'b1;
    tick();
    chk("gate_rst.idle", 32'(busy_of(1'b0)), 32'd0);
    run_win(1'b0, 0, 1'b1, 1'b0, -1, "after_rst");

    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (256) tick();
    chk("send_rst.pre", 32'(valid_of(1'b0)), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("send_rst.valid", 32'(valid_of(1'b0)), 32'd0);
    rst_n = 1'b1;
    tick();

    set_pat(1, 16, 1);
    run_win(1'b0, 0, 1'b1, 1'b0, -1, "glitch");

    for (int k = 0; k < 5; k++) begin
      p     = $urandom_range(12, 4);
      h     = $urandom_range(p - 2, 2);
      g     = $urandom_range(1, 0);
      chain = $urandom_range(2, 1);
      set_pat(1, p, h);
      for (int j = 0; j < chain; j++)
        run_win(1'b0, g, j == 0, j < chain - 1, -1, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
